// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: a CPU-visible TX FIFO feeding an 8N1 serializer.
// Register window: TXDATA, STATUS, DIV, reserved; reads return one cycle after the access.
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR    = 32'hFFFF_FF10,
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter int unsigned CLKS_PER_BIT = 104
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dmem_wren,
    input  logic [31:0] dmem_address,
    input  logic [31:0] dmem_data_in,
    input  logic [2:0]  funct3,
    output logic [31:0] dmem_data_out,
    output logic        rd_hit,
    output logic        uart_tx
);
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [PtrW-1:0] r_wptr, r_rptr;
    logic [CntW-1:0] r_count;
    logic            r_ovf;
    logic [15:0]     r_div;
    state_e          r_state, w_state_d;
    logic [7:0]      r_shift, w_shift_d;
    logic [15:0]     r_bit_div, w_bit_div_d;
    logic [15:0]     r_timer, w_timer_d;
    logic [2:0]      r_bit_idx, w_bit_idx_d;
    logic            r_tx, w_tx_d;
    logic            r_rd_hit;
    logic [31:0]     r_rdata;

    logic        w_hit, w_full, w_empty, w_busy, w_bit_end;
    logic [1:0]  w_off;
    logic        w_push_req, w_push, w_pop, w_drop, w_ovf_clr, w_div_wr;
    logic [15:0] w_div_new;
    logic [4:0]  w_count5;
    logic [31:0] w_status, w_rdata;
    logic        w_unused;

    assign w_unused   = ^{funct3, dmem_address[1:0], dmem_data_in[31:16]};

    assign w_hit      = (dmem_address[31:4] == BASE_ADDR[31:4]);
    assign w_off      = dmem_address[3:2];
    assign w_full     = (r_count == CntW'(FIFO_DEPTH));
    assign w_empty    = (r_count == '0);
    assign w_busy     = (r_state != StIdle);
    assign w_bit_end  = (r_timer == r_bit_div - 16'd1);

    assign w_push_req = w_hit & dmem_wren & (w_off == 2'd0);
    // A pop on the same edge frees a slot, so a push into a full FIFO is still accepted.
    assign w_push     = w_push_req & (~w_full | w_pop);
    assign w_drop     = w_push_req & w_full & ~w_pop;
    assign w_ovf_clr  = w_hit & dmem_wren & (w_off == 2'd1) & dmem_data_in[3];
    assign w_div_wr   = w_hit & dmem_wren & (w_off == 2'd2);
    assign w_div_new  = (dmem_data_in[15:0] < 16'd2) ? 16'd2 : dmem_data_in[15:0];

    assign w_count5   = 5'(r_count);
    assign w_status   = {19'b0, w_count5, 4'b0, r_ovf, w_empty, w_full, w_busy};

    always_comb begin
        w_rdata = '0;
        case (w_off)
            2'd1:    w_rdata = w_status;
            2'd2:    w_rdata = {16'h0, r_div};
            default: w_rdata = '0;
        endcase
    end

    always_comb begin
        w_state_d   = r_state;
        w_shift_d   = r_shift;
        w_bit_div_d = r_bit_div;
        w_timer_d   = r_timer;
        w_bit_idx_d = r_bit_idx;
        w_tx_d      = r_tx;
        w_pop       = 1'b0;
        unique case (r_state)
            StIdle: begin
                w_tx_d    = 1'b1;
                w_timer_d = '0;
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_shift_d   = r_mem[r_rptr];
                    w_bit_div_d = r_div;
                    w_state_d   = StStart;
                    w_tx_d      = 1'b0;
                end
            end
            StStart: begin
                if (w_bit_end) begin
                    w_timer_d   = '0;
                    w_bit_idx_d = '0;
                    w_state_d   = StData;
                    w_tx_d      = r_shift[0];
                end else begin
                    w_timer_d = r_timer + 16'd1;
                end
            end
            StData: begin
                if (w_bit_end) begin
                    w_timer_d = '0;
                    if (r_bit_idx == 3'd7) begin
                        w_state_d = StStop;
                        w_tx_d    = 1'b1;
                    end else begin
                        w_bit_idx_d = r_bit_idx + 3'd1;
                        w_shift_d   = {1'b0, r_shift[7:1]};
                        w_tx_d      = r_shift[1];
                    end
                end else begin
                    w_timer_d = r_timer + 16'd1;
                end
            end
            StStop: begin
                if (w_bit_end) begin
                    w_timer_d = '0;
                    // Chain straight into the next START so queued bytes leave no idle gap.
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_shift_d   = r_mem[r_rptr];
                        w_bit_div_d = r_div;
                        w_state_d   = StStart;
                        w_tx_d      = 1'b0;
                    end else begin
                        w_state_d = StIdle;
                        w_tx_d    = 1'b1;
                    end
                end else begin
                    w_timer_d = r_timer + 16'd1;
                end
            end
            default: begin
                w_state_d = StIdle;
                w_tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= dmem_data_in[7:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_ovf     <= 1'b0;
            r_div     <= 16'(CLKS_PER_BIT);
            r_state   <= StIdle;
            r_shift   <= '0;
            r_bit_div <= 16'(CLKS_PER_BIT);
            r_timer   <= '0;
            r_bit_idx <= '0;
            r_tx      <= 1'b1;
            r_rd_hit  <= 1'b0;
            r_rdata   <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PtrW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PtrW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CntW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CntW'(1);
            end
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (w_ovf_clr) begin
                r_ovf <= 1'b0;
            end
            if (w_div_wr) begin
                r_div <= w_div_new;
            end
            r_state   <= w_state_d;
            r_shift   <= w_shift_d;
            r_bit_div <= w_bit_div_d;
            r_timer   <= w_timer_d;
            r_bit_idx <= w_bit_idx_d;
            r_tx      <= w_tx_d;
            r_rd_hit  <= w_hit & ~dmem_wren;
            r_rdata   <= (w_hit & ~dmem_wren) ? w_rdata : 32'h0;
        end
    end

    assign dmem_data_out = r_rdata;
    assign rd_hit        = r_rd_hit;
    assign uart_tx       = r_tx;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: register vector table, frame scoreboard decoded off uart_tx,
// and hand sequences for latency, back-to-back frames, overflow and mid-frame reset.
module tb_mmio_uart_tx;
    localparam logic [31:0] BASE = 32'hFFFF_FF10;

    logic        clk = 1'b0;
    logic        reset;
    logic        dmem_wren;
    logic [31:0] dmem_address;
    logic [31:0] dmem_data_in;
    logic [2:0]  funct3;
    logic [31:0] dmem_data_out;
    logic        rd_hit;
    logic        uart_tx;

    mmio_uart_tx dut (
        .clk           (clk),
        .reset         (reset),
        .dmem_wren     (dmem_wren),
        .dmem_address  (dmem_address),
        .dmem_data_in  (dmem_data_in),
        .funct3        (funct3),
        .dmem_data_out (dmem_data_out),
        .rd_hit        (rd_hit),
        .uart_tx       (uart_tx)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Scoreboard of bytes expected on the line, in order.
    logic [7:0]  sb [$];
    int unsigned mon_starts [$];
    int          mon_div = 104;
    bit          mon_en  = 1'b0;
    logic [9:0]  mon_bits;
    bit          mon_ok;
    int          mon_n;
    logic [7:0]  mon_exp;

    initial begin
        forever begin
            @(posedge clk); #2;
            if (mon_en && uart_tx === 1'b0) begin
                mon_starts.push_back(cyc);
                mon_ok = 1'b1;
                mon_n  = 10 * mon_div;
                for (int k = 0; k < mon_n; k++) begin
                    if (k % mon_div == mon_div / 2) mon_bits[k / mon_div] = uart_tx;
                    if (k != mon_n - 1) begin
                        @(posedge clk); #2;
                    end
                    if (!mon_en) begin
                        mon_ok = 1'b0;
                        break;
                    end
                end
                if (mon_ok) begin
                    if (sb.size() == 0) begin
                        n_checks++;
                        $display("FAIL frame: got frame %b, expected no frame", mon_bits);
                    end else begin
                        mon_exp = sb.pop_front();
                        chk("frame", 64'(mon_bits), 64'({1'b1, mon_exp, 1'b0}));
                    end
                end
            end
        end
    end

    // All bus tasks start and end 1 time unit after a rising edge.
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        dmem_wren = 1'b1; dmem_address = a; dmem_data_in = d;
        @(posedge clk); #1;
        dmem_wren = 1'b0; dmem_address = 32'h0; dmem_data_in = 32'h0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [32:0] r);
        dmem_wren = 1'b0; dmem_address = a;
        @(posedge clk); #1;
        r = {rd_hit, dmem_data_out};
        dmem_address = 32'h0;
    endtask

    task automatic tx_store(input logic [7:0] b, input bit accept);
        if (accept) sb.push_back(b);
        bus_write(BASE, {24'h0, b});
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_remaining", 64'(sb.size()), 64'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_hit;
        logic [31:0] exp_data;
    } vec_t;

    vec_t        vecs [$];
    logic [32:0] r;
    int          low_seen;
    int unsigned d0, d1;

    initial begin
        reset = 1'b1; dmem_wren = 1'b0; dmem_address = 32'h0;
        dmem_data_in = 32'h0; funct3 = 3'b010;

        vecs.push_back('{1'b0, 32'hFFFF_FF14, 32'h0,          1'b1, 32'h0000_0004});
        vecs.push_back('{1'b0, 32'hFFFF_FF18, 32'h0,          1'b1, 32'h0000_0068});
        vecs.push_back('{1'b0, 32'hFFFF_FF10, 32'h0,          1'b1, 32'h0});
        vecs.push_back('{1'b0, 32'hFFFF_FF1C, 32'h0,          1'b1, 32'h0});
        vecs.push_back('{1'b1, 32'hFFFF_FF18, 32'h0001_2345,  1'b0, 32'h0});
        vecs.push_back('{1'b0, 32'hFFFF_FF18, 32'h0,          1'b1, 32'h0000_2345});
        vecs.push_back('{1'b1, 32'hFFFF_FF18, 32'h1,          1'b0, 32'h0});
        vecs.push_back('{1'b0, 32'hFFFF_FF18, 32'h0,          1'b1, 32'h2});
        vecs.push_back('{1'b1, 32'hFFFF_FF18, 32'h0,          1'b0, 32'h0});
        vecs.push_back('{1'b0, 32'hFFFF_FF18, 32'h0,          1'b1, 32'h2});
        vecs.push_back('{1'b1, 32'hFFFF_FF1C, 32'hFFFF_FFFF,  1'b0, 32'h0});
        vecs.push_back('{1'b0, 32'hFFFF_FF1C, 32'h0,          1'b1, 32'h0});
        vecs.push_back('{1'b1, 32'h0000_1000, 32'h0000_00AB,  1'b0, 32'h0});
        vecs.push_back('{1'b0, 32'hFFFF_FF14, 32'h0,          1'b1, 32'h4});
        vecs.push_back('{1'b0, 32'hFFFF_FF20, 32'h0,          1'b0, 32'h0});
        vecs.push_back('{1'b1, 32'hFFFF_FF20, 32'h9,          1'b0, 32'h0});
        vecs.push_back('{1'b0, 32'hFFFF_FF18, 32'h0,          1'b1, 32'h2});
        vecs.push_back('{1'b1, 32'hFFFF_FF18, 32'h4,          1'b0, 32'h0});
        vecs.push_back('{1'b0, 32'hFFFF_FF18, 32'h0,          1'b1, 32'h4});
        vecs.push_back('{1'b1, 32'hFFFF_FF14, 32'h8,          1'b0, 32'h0});
        vecs.push_back('{1'b0, 32'hFFFF_FF14, 32'h0,          1'b1, 32'h4});

        repeat (3) @(posedge clk);
        #1;
        chk("reset_tx", 64'(uart_tx), 64'd1);
        chk("reset_read", 64'({rd_hit, dmem_data_out}), 64'd0);
        reset = 1'b0;

        low_seen = 0;
        foreach (vecs[i]) begin
            dmem_wren    = vecs[i].wr;
            dmem_address = vecs[i].addr;
            dmem_data_in = vecs[i].wdata;
            @(posedge clk); #1;
            if (uart_tx !== 1'b1) low_seen++;
            chk($sformatf("vec%0d", i), 64'({rd_hit, dmem_data_out}),
                64'({vecs[i].exp_hit, vecs[i].exp_data}));
        end
        dmem_wren = 1'b0; dmem_address = 32'h0; dmem_data_in = 32'h0;
        chk("idle_line_low_cycles", 64'(low_seen), 64'd0);

        // Single frame, DIV=4: start bit appears two edges after the store.
        mon_div = 4;
        mon_en  = 1'b1;
        tx_store(8'hA5, 1'b1);
        chk("tx_after_store_edge", 64'(uart_tx), 64'd1);
        @(posedge clk); #1;
        chk("tx_start_latency", 64'(uart_tx), 64'd0);
        bus_read(BASE + 32'h4, r);
        chk("status_busy", 64'(r), 64'({1'b1, 32'h5}));
        wait_drain(200);
        bus_read(BASE + 32'h4, r);
        chk("status_idle_after_frame", 64'(r), 64'({1'b1, 32'h4}));

        // Back-to-back frames with no idle gap.
        mon_starts.delete();
        tx_store(8'h01, 1'b1);
        tx_store(8'h02, 1'b1);
        tx_store(8'h03, 1'b1);
        for (int n = 0; n < 300 && mon_starts.size() < 3; n++) begin
            @(posedge clk); #1;
        end
        chk("b2b_frames_started", 64'(mon_starts.size()), 64'd3);
        bus_read(BASE + 32'h4, r);
        chk("status_empty_after_third_pop", 64'(r), 64'({1'b1, 32'h5}));
        if (mon_starts.size() >= 3) begin
            d0 = mon_starts[1] - mon_starts[0];
            d1 = mon_starts[2] - mon_starts[1];
            chk("b2b_gap_1_2", 64'(d0), 64'd40);
            chk("b2b_gap_2_3", 64'(d1), 64'd40);
        end
        wait_drain(300);

        // Overflow: 11 consecutive stores, one popped, 8 queued, 2 dropped.
        bus_write(BASE + 32'h8, 32'd100);
        mon_div = 100;
        for (int i = 0; i < 11; i++) tx_store(8'h10 + 8'(i), i < 9);
        bus_read(BASE + 32'h4, r);
        chk("status_full_ovf", 64'(r), 64'({1'b1, 32'h0000_080B}));
        bus_write(BASE + 32'h4, 32'h8);
        bus_read(BASE + 32'h4, r);
        chk("status_ovf_cleared", 64'(r), 64'({1'b1, 32'h0000_0803}));
        bus_read(BASE + 32'h8, r);
        chk("div_100", 64'(r), 64'({1'b1, 32'd100}));
        wait_drain(12000);
        bus_read(BASE + 32'h4, r);
        chk("status_after_overflow_drain", 64'(r), 64'({1'b1, 32'h4}));

        // Reset during data bit 3 of 0xF7 (bit3 = 0) with two more bytes queued.
        mon_en = 1'b0;
        bus_write(BASE + 32'h8, 32'd4);
        tx_store(8'hF7, 1'b0);
        tx_store(8'h55, 1'b0);
        tx_store(8'hAA, 1'b0);
        repeat (17) @(posedge clk);
        #2;
        chk("tx_data_bit3_before_reset", 64'(uart_tx), 64'd0);
        reset = 1'b1;
        #1;
        chk("tx_high_on_async_reset", 64'(uart_tx), 64'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        bus_read(BASE + 32'h4, r);
        chk("status_after_reset", 64'(r), 64'({1'b1, 32'h4}));
        bus_read(BASE + 32'h8, r);
        chk("div_after_reset", 64'(r), 64'({1'b1, 32'd104}));
        low_seen = 0;
        for (int n = 0; n < 60; n++) begin
            @(posedge clk); #1;
            if (uart_tx !== 1'b1) low_seen++;
        end
        chk("queued_bytes_lost", 64'(low_seen), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter that responds to the core's data-memory bus (dmem_address / dmem_data_in / dmem_wren / funct3 / dmem_data_out).
- Sits beside the memory block as a bus responder; the top-level read mux selects dmem_data_out from this block when rd_hit is high.
- CPU stores bytes into a TX FIFO; an internal serializer drives 8N1 frames on uart_tx, LSB first.

Parameters:
- BASE_ADDR, 32'hFFFFFF10, 16-byte-aligned base of the register window.
- FIFO_DEPTH, 8, TX FIFO entries; power of 2, 2..16.
- CLKS_PER_BIT, 104, reset value of DIV (12 MHz / 115200).

Ports:
- clk, input, 1, system clock.
- reset, input, 1, asynchronous active-high reset.
- dmem_wren, input, 1, store strobe for the current cycle.
- dmem_address, input, 32, byte address.
- dmem_data_in, input, 32, store data.
- funct3, input, 3, access size; ignored by this block.
- dmem_data_out, output, 32, registered read data.
- rd_hit, output, 1, registered; high when dmem_data_out holds this block's data.
- uart_tx, output, 1, serial line; idles high.

Behaviour:
- Address decode:
  - hit = (dmem_address[31:4] == BASE_ADDR[31:4]); offset = dmem_address[3:2].
  - Offsets: 0 = TXDATA, 1 = STATUS, 2 = DIV, 3 = reserved (reads 0, writes ignored).
- Writes (hit & dmem_wren, sampled at rising edge; any store width accepted):
  - TXDATA pushes dmem_data_in[7:0]. If the FIFO is full and no pop occurs that edge, the byte is dropped and the sticky overflow bit is set. If a pop and a push coincide while full, the push is accepted.
  - STATUS: writing 1 to bit3 clears overflow. A set from a dropped push in the same cycle wins over the clear.
  - DIV: div <= dmem_data_in[15:0], with values below 2 stored as 2. A new DIV applies from the next START; the frame in progress keeps its latched divisor.
- Reads:
  - Every edge: rd_hit <= hit & ~dmem_wren; dmem_data_out <= register value if hit & ~dmem_wren, else 0.
  - One-cycle latency, matching the core's mem_data_reg capture. TXDATA reads 0. DIV reads {16'b0, div}.
- STATUS layout: bit0 busy (state != IDLE), bit1 full, bit2 empty, bit3 overflow, bits[8+:5] FIFO count, all other bits 0.
- Serializer FSM (uart_tx is a registered output):
  - IDLE: uart_tx = 1. If the FIFO is non-empty: pop, load shift register, latch div into bit_div, go START.
  - START: uart_tx = 0 for bit_div cycles, then DATA.
  - DATA: 8 bits LSB first, bit_div cycles each; bit index 0..7, then STOP.
  - STOP: uart_tx = 1 for bit_div cycles. At the end, if the FIFO is non-empty, pop and go straight to START (no idle gap); else go IDLE.
  - Bit timer counts 0..bit_div-1 and wraps.
- Latency: a store sampled at edge E0 into an empty FIFO with the FSM in IDLE gives count=1 after E0 and uart_tx=0 after E1. Frame length is 10*bit_div cycles.
- FIFO: circular with wrap-around pointers; count has range 0..FIFO_DEPTH. Full = (count == FIFO_DEPTH); empty = (count == 0).
- Reset (asynchronous, any time, including mid-frame):
  - uart_tx = 1, state IDLE, FIFO emptied, count 0, overflow 0, div = CLKS_PER_BIT.
  - dmem_data_out = 0, rd_hit = 0.
  - The partial frame is abandoned and queued bytes are lost.
- Stores or loads outside the window: no state change; dmem_data_out = 0 and rd_hit = 0 on the next cycle.

Test Plan:
- Reset, then read STATUS (addr 0xFFFFFF14) -> next cycle rd_hit=1, dmem_data_out=32'h0000_0004; uart_tx=1 throughout.
- Write DIV=4, then sw 0x000000A5 to 0xFFFFFF10 -> uart_tx low 2 edges after the store for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then high for 4 cycles; STATUS busy=1 during the frame.
- DIV=4, three back-to-back stores 0x01, 0x02, 0x03 -> three contiguous 40-cycle frames with no idle cycle between STOP and the next START; STATUS empty=1 after the third pop.
- DIV=100, FIFO_DEPTH=8, eleven stores in consecutive cycles -> first byte popped, 8 queued, remaining 2 dropped; STATUS full=1, overflow=1, count=8. Writing 0x8 to STATUS clears overflow only.
- Store to 0x00001000 and load from 0xFFFFFF20 -> FIFO and DIV unchanged, rd_hit=0, dmem_data_out=0.
- Assert reset mid-DATA bit 3 -> uart_tx=1 immediately; after release, STATUS=32'h4 and DIV reads 104.
